// File: rtl/shift_pkg.sv
// Shared opcodes and helpers for the pipelined shifter.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    function automatic int shamt_w(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Request/response bundle of the pipelined shifter; master is the issuing side.
interface shift_unit_pipe_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] alumux1_out;
    logic [XLEN-1:0] alumux2_out;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] aluout;
    logic [TAGW-1:0] out_tag;

    modport master (
        output flush, in_valid, op, alumux1_out, alumux2_out, in_tag, out_ready,
        input  in_ready, out_valid, aluout, out_tag
    );

    modport slave (
        input  flush, in_valid, op, alumux1_out, alumux2_out, in_tag, out_ready,
        output in_ready, out_valid, aluout, out_tag
    );
endinterface

// File: rtl/shift_stage.sv
// One pipeline stage: barrel levels LVL_LO..LVL_HI followed by a valid/data register.
module shift_stage
    import shift_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int LVL_LO = 0,
    parameter int LVL_HI = 0,
    parameter int TAGW   = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        load_en,
    input  logic                        valid_in,
    input  logic [1:0]                  op_in,
    input  logic [XLEN-1:0]             data_in,
    input  logic [shamt_w(XLEN)-1:0]    sh_in,
    input  logic [TAGW-1:0]             tag_in,
    output logic                        valid_out,
    output logic [1:0]                  op_out,
    output logic [XLEN-1:0]             data_out,
    output logic [shamt_w(XLEN)-1:0]    sh_out,
    output logic [TAGW-1:0]             tag_out
);

    localparam int NLVL = (LVL_HI >= LVL_LO) ? (LVL_HI - LVL_LO + 1) : 0;

    function automatic logic [XLEN-1:0] shift_by(input logic [1:0] op,
                                                 input logic [XLEN-1:0] d,
                                                 input int k);
        logic [XLEN-1:0] r;
        unique case (op)
            OP_SLL:  r = d << k;
            OP_SRL:  r = d >> k;
            OP_SRA:  r = $signed(d) >>> k;
            default: r = (d >> k) | (d << (XLEN - k));
        endcase
        return r;
    endfunction

    // lvl[0] is the stage input; each level conditionally shifts by its power of two.
    logic [NLVL:0][XLEN-1:0] lvl;
    assign lvl[0] = data_in;

    for (genvar g = 0; g < NLVL; g++) begin : g_lvl
        localparam int K = 1 << (LVL_LO + g);
        assign lvl[g+1] = sh_in[LVL_LO+g] ? shift_by(op_in, lvl[g], K) : lvl[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            op_out    <= '0;
            data_out  <= '0;
            sh_out    <= '0;
            tag_out   <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (load_en) begin
            valid_out <= valid_in;
            if (valid_in) begin
                op_out   <= op_in;
                data_out <= lvl[NLVL];
                sh_out   <= sh_in;
                tag_out  <= tag_in;
            end
        end
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA/ROR shifter with an elastic valid/ready chain and synchronous flush.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAGW   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_unit_pipe_if.slave    bus
);

    localparam int SHW = shamt_w(XLEN);
    localparam int PER = (SHW + STAGES - 1) / STAGES;

    // Index 0 is the incoming request, index s+1 the register of stage s.
    logic [STAGES:0]                valid_c;
    logic [STAGES:0][1:0]           op_c;
    logic [STAGES:0][XLEN-1:0]      data_c;
    logic [STAGES:0][SHW-1:0]       sh_c;
    logic [STAGES:0][TAGW-1:0]      tag_c;
    logic [STAGES-1:0]              ready_c;

    assign valid_c[0] = bus.in_valid;
    assign op_c[0]    = bus.op;
    assign data_c[0]  = bus.alumux1_out;
    assign sh_c[0]    = bus.alumux2_out[SHW-1:0];
    assign tag_c[0]   = bus.in_tag;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO     = s * PER;
        localparam int HI_END = ((s + 1) * PER > SHW) ? SHW : (s + 1) * PER;

        // A stage may load when the output drains or any stage downstream of it holds a bubble.
        assign ready_c[s] = bus.out_ready | ~(&valid_c[STAGES:s+1]);

        shift_stage #(
            .XLEN   (XLEN),
            .LVL_LO (LO),
            .LVL_HI (HI_END - 1),
            .TAGW   (TAGW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (bus.flush),
            .load_en   (ready_c[s]),
            .valid_in  (valid_c[s]),
            .op_in     (op_c[s]),
            .data_in   (data_c[s]),
            .sh_in     (sh_c[s]),
            .tag_in    (tag_c[s]),
            .valid_out (valid_c[s+1]),
            .op_out    (op_c[s+1]),
            .data_out  (data_c[s+1]),
            .sh_out    (sh_c[s+1]),
            .tag_out   (tag_c[s+1])
        );
    end

    assign bus.in_ready  = ready_c[0] | bus.flush;
    assign bus.out_valid = valid_c[STAGES];
    assign bus.aluout    = data_c[STAGES];
    assign bus.out_tag   = tag_c[STAGES];

    logic unused_bits;
    assign unused_bits = ^{bus.alumux2_out[XLEN-1:SHW], op_c[STAGES], sh_c[STAGES]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench: queue-based reference model plus directed vectors with literal results.
module tb_shift_unit_pipe;
    import shift_pkg::*;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAGW   = 5;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [TAGW-1:0] tag;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_unit_pipe_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

    shift_unit_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAGW(TAGW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    int              stall_accepts = 0;
    exp_t            q[$];
    logic [XLEN-1:0] cur_exp;
    logic            cur_has_exp = 1'b0;

    function automatic logic [XLEN-1:0] model(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $signed(a) >>> sh;
            default: return (sh == 0) ? a : ((a >> sh) | (a << (XLEN - sh)));
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model and compare process, sampled mid-cycle.
    always @(negedge clk) begin
        logic exp_valid;
        cyc++;
        if (!rst_n) begin
            q.delete();
            checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 0);
            checkOutput("reset_aluout", bus.aluout, 0);
            checkOutput("reset_out_tag", {27'b0, bus.out_tag}, 0);
        end else begin
            exp_valid = (q.size() > 0) && (cyc >= q[0].cyc + STAGES);
            checkOutput("in_ready", {31'b0, bus.in_ready},
                        {31'b0, bus.flush || bus.out_ready || (q.size() < STAGES)});
            checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_valid});
            if (bus.out_valid && q.size() > 0) begin
                checkOutput("aluout", bus.aluout, q[0].res);
                checkOutput("out_tag", {27'b0, bus.out_tag}, {27'b0, q[0].tag});
                if (bus.out_ready) void'(q.pop_front());
            end
            if (bus.flush) begin
                q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e.res = model(bus.op, bus.alumux1_out, bus.alumux2_out);
                if (cur_has_exp) begin
                    checkOutput("model_pin", e.res, cur_exp);
                    e.res = cur_exp;
                end
                e.tag = bus.in_tag;
                e.cyc = cyc;
                q.push_back(e);
                if (!bus.out_ready) stall_accepts++;
            end
        end
    end

    // Called right after a rising edge; returns right after the edge that accepted the request.
    task automatic applyStimulus(input logic [1:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [TAGW-1:0] tag,
                                 input logic [XLEN-1:0] exp, input logic has_exp);
        int n = 0;
        bus.op          = op;
        bus.alumux1_out = a;
        bus.alumux2_out = b;
        bus.in_tag      = tag;
        bus.in_valid    = 1'b1;
        cur_exp         = exp;
        cur_has_exp     = has_exp;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n >= 100) begin
                checkOutput("accept_timeout", {31'b0, bus.in_ready}, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cur_has_exp  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flushCycle(input logic keep_ready);
        bus.flush       = 1'b1;
        bus.out_ready   = keep_ready;
        bus.in_valid    = 1'b1;
        bus.op          = OP_SLL;
        bus.alumux1_out = 32'hDEAD_BEEF;
        bus.alumux2_out = 32'd4;
        bus.in_tag      = 5'd31;
        idle(1);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.op          = OP_SLL;
        bus.alumux1_out = '0;
        bus.alumux2_out = '0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        $display("[TB] directed vectors");
        applyStimulus(OP_SLL, 32'h0000_0001, 32'd1,  5'd1, 32'h0000_0002, 1'b1);
        applyStimulus(OP_SLL, 32'h0000_0000, 32'd0,  5'd2, 32'h0000_0000, 1'b1);
        applyStimulus(OP_SRL, 32'hFFFF_0000, 32'd8,  5'd3, 32'h00FF_FF00, 1'b1);
        applyStimulus(OP_SRA, 32'hFFFF_FFFE, 32'd8,  5'd4, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(OP_SRA, 32'h7FFF_FFFF, 32'd31, 5'd5, 32'h0000_0000, 1'b1);
        applyStimulus(OP_ROR, 32'h8000_0001, 32'd4,  5'd6, 32'h1800_0000, 1'b1);
        applyStimulus(OP_SLL, 32'h0000_0001, 32'h28, 5'd7, 32'h0000_0100, 1'b1);
        applyStimulus(OP_ROR, 32'h1234_5678, 32'd0,  5'd8, 32'h1234_5678, 1'b1);
        applyStimulus(OP_ROR, 32'h0000_0001, 32'd31, 5'd9, 32'h0000_0002, 1'b1);
        applyStimulus(OP_SRA, 32'h8000_0000, 32'd31, 5'd10, 32'hFFFF_FFFF, 1'b1);
        idle(4);

        $display("[TB] back-to-back burst");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'(i), 32'hA5C3_0F17 ^ (32'(i) * 32'h0101_0101),
                          32'(i * 5 + 3), 5'(i), '0, 1'b0);
        end
        idle(4);

        $display("[TB] output stall");
        stall_accepts = 0;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    applyStimulus(OP_SRL, 32'hF0F0_1234 + 32'(i), 32'(i + 1), 5'(8 + i), '0, 1'b0);
            end
            begin
                idle(5);
                bus.out_ready = 1'b1;
            end
        join
        checkOutput("stall_accepts", 32'(stall_accepts), 32'd2);
        idle(6);

        $display("[TB] flush while draining");
        applyStimulus(OP_SLL, 32'h0000_00FF, 32'd4, 5'd20, '0, 1'b0);
        applyStimulus(OP_SLL, 32'h0000_00FF, 32'd8, 5'd21, '0, 1'b0);
        flushCycle(1'b1);
        idle(4);
        applyStimulus(OP_ROR, 32'h0000_00F0, 32'd8, 5'd22, 32'hF000_0000, 1'b1);
        idle(4);

        $display("[TB] flush while stalled");
        applyStimulus(OP_SRL, 32'h8000_0000, 32'd1, 5'd23, '0, 1'b0);
        applyStimulus(OP_SRL, 32'h8000_0000, 32'd2, 5'd24, '0, 1'b0);
        flushCycle(1'b0);
        idle(4);
        applyStimulus(OP_SRA, 32'h8000_0000, 32'd4, 5'd25, 32'hF800_0000, 1'b1);
        idle(4);

        $display("[TB] reset mid-stream");
        applyStimulus(OP_SLL, 32'h0000_0003, 32'd2, 5'd26, '0, 1'b0);
        applyStimulus(OP_SLL, 32'h0000_0003, 32'd3, 5'd27, '0, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        applyStimulus(OP_SRL, 32'h0001_0000, 32'd16, 5'd28, 32'h0000_0001, 1'b1);

        for (int n = 0; n < 50 && q.size() > 0; n++) @(posedge clk);
        #1;
        checkOutput("drain_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
